// File: rtl/ps2_key_event_sequencer.sv
// ps2_key_event_sequencer: PS/2 scan bytes -> make/break key events in a FIFO.
// Strips 0xE0/0xF0 prefixes, drops non-key bytes, times out stale prefixes.
// Ports: clk, reset (async, high); scan_ready/scan_code in;
//   event_valid/event_ready handshake with event_code/extended/break;
//   overflow (sticky, cleared by overflow_clear); protocol_error (pulse).
// Option: define PS2_KEY_REPEAT_FILTER_EN to drop typematic make repeats.
module ps2_key_event_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [7:0] event_code,
  output logic       event_extended,
  output logic       event_break,
  output logic       overflow,
  input  logic       overflow_clear,
  output logic       protocol_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   F_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_ext, w_ext_nx;
  logic [TW-1:0] r_tcnt;
  logic          w_expire;
  logic          w_is_e0, w_is_f0, w_is_noise;
  logic          w_dec_v, w_dec_ext, w_dec_brk;
  logic          w_err_nx, w_rep, w_push_nx;
  logic          r_pv, r_pext, r_pbrk;
  logic [7:0]    r_pcode;
  logic          r_err;

  assign w_is_e0    = scan_code == 8'hE0;
  assign w_is_f0    = scan_code == 8'hF0;
  assign w_is_noise = scan_code inside {8'h00, 8'hFF, 8'hAA, 8'hFA,
                                        8'hFE, 8'hFC, 8'hEE, 8'hE1};

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_expire = (r_state != S_IDLE) && !scan_ready &&
                    (r_tcnt == T_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_ext_nx   = r_ext;
    w_dec_v    = 1'b0;
    w_dec_ext  = 1'b0;
    w_dec_brk  = 1'b0;
    w_err_nx   = 1'b0;
    if (scan_ready) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_is_e0: w_state_nx = S_EXT;
            w_is_f0: begin
              w_state_nx = S_BRK;
              w_ext_nx   = 1'b0;
            end
            w_is_noise: begin
            end
            default: w_dec_v = 1'b1;
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            w_is_f0: begin
              w_state_nx = S_BRK;
              w_ext_nx   = 1'b1;
            end
            w_is_e0: w_err_nx = 1'b1;
            default: begin
              w_dec_v    = 1'b1;
              w_dec_ext  = 1'b1;
              w_state_nx = S_IDLE;
              w_ext_nx   = 1'b0;
            end
          endcase
        end
        S_BRK: begin
          w_state_nx = S_IDLE;
          w_ext_nx   = 1'b0;
          if (w_is_e0 || w_is_f0) begin
            w_err_nx = 1'b1;
          end else begin
            w_dec_v   = 1'b1;
            w_dec_ext = r_ext;
            w_dec_brk = 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_ext_nx   = 1'b0;
        end
      endcase
    end else if (w_expire) begin
      w_state_nx = S_IDLE;
      w_ext_nx   = 1'b0;
      w_err_nx   = 1'b1;
    end
  end

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic       r_lm_v, r_lm_ext;
  logic [7:0] r_lm_code;
  logic       w_lm_hit;

  assign w_lm_hit = r_lm_v && (r_lm_ext == w_dec_ext) &&
                    (r_lm_code == scan_code);
  assign w_rep    = w_dec_v && !w_dec_brk && w_lm_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lm_v    <= 1'b0;
      r_lm_ext  <= 1'b0;
      r_lm_code <= 8'h00;
    end else if (w_dec_v) begin
      if (!w_dec_brk) begin
        r_lm_v    <= 1'b1;
        r_lm_ext  <= w_dec_ext;
        r_lm_code <= scan_code;
      end else if (w_lm_hit) begin
        r_lm_v <= 1'b0;
      end
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  assign w_push_nx = w_dec_v && !w_rep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ext   <= 1'b0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_pv    <= 1'b0;
      r_pcode <= 8'h00;
      r_pext  <= 1'b0;
      r_pbrk  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ext   <= w_ext_nx;
      r_err   <= w_err_nx;
      r_pv    <= w_push_nx;
      r_pcode <= scan_code;
      r_pext  <= w_dec_ext;
      r_pbrk  <= w_dec_brk;
      if (scan_ready || (w_state_nx == S_IDLE))
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_full, w_pop, w_wr;
  logic [9:0]    w_head;

  assign w_full = r_cnt == F_FULL;
  assign w_pop  = event_valid && event_ready;
  assign w_wr   = r_pv && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {r_pcode, r_pext, r_pbrk};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (r_pv && !w_wr)
        r_ovf <= 1'b1;
      else if (overflow_clear)
        r_ovf <= 1'b0;
    end
  end

  // Head fields read as zero while empty so stale entries never leak.
  assign event_valid = r_cnt != '0;
  assign w_head      = event_valid ? r_mem[r_rptr] : 10'd0;
  assign event_code     = w_head[9:2];
  assign event_extended = w_head[1];
  assign event_break    = w_head[0];
  assign overflow       = r_ovf;
  assign protocol_error = r_err;
endmodule
